// File: rtl/ram_param.sv
// Single-port synchronous RAM (DEPTH x WIDTH) with a sequenced fill command; read data is registered, one-cycle latency.
// No backpressure: accesses and fill requests arriving while busy are dropped, not stalled.
module ram_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  read_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WIDTH-1:0]      data,
    input  logic                  fill,
    input  logic [WIDTH-1:0]      fill_data,
    output logic [WIDTH-1:0]      saved_data,
    output logic                  valid,
    output logic                  busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [WIDTH-1:0]      fill_reg;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  in_range;
    logic                  idle_access;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_dat;
    logic [WIDTH-1:0]      rd_word;

    assign in_range    = {1'b0, address} < DEPTH_LIM;
    // A fill request in IDLE pre-empts any access presented in the same cycle.
    assign idle_access = (state == S_IDLE) && !fill && enable;
    assign rd_en       = idle_access && !read_write;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_dat  = '0;
        if (state == S_FILL) begin
            wr_en   = 1'b1;
            wr_addr = fill_cnt;
            wr_dat  = fill_reg;
        end else if (idle_access && read_write && in_range) begin
            wr_en   = 1'b1;
            wr_addr = address;
            wr_dat  = data;
        end
    end

    // Out-of-range reads return zero rather than aliasing onto a real word.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[address];
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            saved_data <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= rd_en;
            if (rd_en) begin
                saved_data <= rd_word;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_IDLE;
            fill_cnt <= '0;
            fill_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fill) begin
                        fill_reg <= fill_data;
                        fill_cnt <= '0;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (fill_cnt == LAST_IDX) begin
                        fill_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (state == S_FILL);

endmodule
